// File: rtl/wvl_capture_ctrl_pkg.sv
// Shared types and bit positions for the capture sequencer:
// the state encoding, the cfg_ctrl bit map and the status word layout.
package wvl_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_e;

  localparam int ARM_BIT   = 0;
  localparam int CAL_BIT   = 1;
  localparam int ABORT_BIT = 2;

  localparam int STAT_ARMED     = 0;
  localparam int STAT_CAPTURING = 1;
  localparam int STAT_DONE      = 2;
  localparam int STAT_SAT       = 3;
  localparam int STAT_ABORTED   = 4;

  function automatic logic [31:0] pack_status(input logic armed, input logic capturing,
                                              input logic done, input logic sat,
                                              input logic aborted);
    logic [31:0] s;
    s                 = '0;
    s[STAT_ARMED]     = armed;
    s[STAT_CAPTURING] = capturing;
    s[STAT_DONE]      = done;
    s[STAT_SAT]       = sat;
    s[STAT_ABORTED]   = aborted;
    return s;
  endfunction

endpackage

// File: rtl/wvl_capture_ctrl_if.sv
// Register-side and datapath-side signals of the capture sequencer.
// The master drives configuration and datapath strobes; the slave is the sequencer.
interface wvl_capture_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      cfg_ctrl;
  logic [CNT_W-1:0] cfg_num_frames;
  logic             frame_sync;
  logic             photon_valid;
  logic             cap_window;
  logic             use_energy_cal;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] photon_cnt;
  logic [31:0]      status;

  modport master (
    output cfg_ctrl, cfg_num_frames, frame_sync, photon_valid,
    input  cap_window, use_energy_cal, frame_cnt, photon_cnt, status
  );

  modport slave (
    input  cfg_ctrl, cfg_num_frames, frame_sync, photon_valid,
    output cap_window, use_energy_cal, frame_cnt, photon_cnt, status
  );
endinterface

// File: rtl/wvl_capture_ctrl_sat_counter.sv
// Saturating up-counter with a sticky saturation flag; clear has priority
// over increment and also drops the flag.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);
  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] cnt_q;
  logic         sat_q;

  always_ff @(posedge clk) begin
    if (srst || clr_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (inc_i && (cnt_q != MAX_VAL)) begin
      cnt_q <= cnt_q + 1'b1;
      // flag as soon as the ceiling is reached
      if (cnt_q == MAX_VAL - 1'b1) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;
endmodule

// File: rtl/wvl_capture_ctrl.sv
// Capture sequencer: arms on a software edge, opens the datapath write window
// on whole-frame boundaries, switches energy calibration only at frame starts.
module wvl_capture_ctrl
  import wvl_capture_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               user_clk,
  input logic               user_rst,
  wvl_capture_ctrl_if.slave bus
);
  cap_state_e       state_q, state_d;
  logic             arm_hist_q, abort_hist_q;
  logic             cal_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] num_frames_q, num_frames_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             arm_p, abort_p;
  logic             phot_clr, phot_inc, phot_sat;
  logic [CNT_W-1:0] phot_cnt;
  logic             ctrl_unused;

  assign arm_p       = bus.cfg_ctrl[ARM_BIT] & ~arm_hist_q;
  assign abort_p     = bus.cfg_ctrl[ABORT_BIT] & ~abort_hist_q;
  assign ctrl_unused = ^bus.cfg_ctrl[31:3];

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q      <= ST_IDLE;
      arm_hist_q   <= 1'b0;
      abort_hist_q <= 1'b0;
      cal_q        <= 1'b0;
      frame_cnt_q  <= '0;
      num_frames_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_hist_q   <= bus.cfg_ctrl[ARM_BIT];
      abort_hist_q <= bus.cfg_ctrl[ABORT_BIT];
      if (bus.frame_sync) begin
        cal_q <= bus.cfg_ctrl[CAL_BIT];
      end
      frame_cnt_q  <= frame_cnt_d;
      num_frames_q <= num_frames_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    num_frames_d = num_frames_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    phot_clr     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // a new run clears the previous run's results in the same step
        if (arm_p) begin
          state_d      = ST_ARMED;
          frame_cnt_d  = '0;
          num_frames_d = bus.cfg_num_frames;
          done_d       = 1'b0;
          aborted_d    = 1'b0;
          phot_clr     = 1'b1;
        end else if (abort_p) begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (abort_p) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (bus.frame_sync) begin
          state_d     = ST_CAPT;
          frame_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CAPT: begin
        if (abort_p) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (bus.frame_sync) begin
          // the sync that would start frame N+1 closes the window instead
          if ((num_frames_q != '0) && (frame_cnt_q == num_frames_q)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign phot_inc = bus.photon_valid & (state_q == ST_CAPT);

  sat_counter #(
    .W(CNT_W)
  ) u_photon_cnt (
    .clk   (user_clk),
    .srst  (user_rst),
    .clr_i (phot_clr),
    .inc_i (phot_inc),
    .cnt_o (phot_cnt),
    .sat_o (phot_sat)
  );

  assign bus.cap_window     = (state_q == ST_CAPT);
  assign bus.use_energy_cal = cal_q;
  assign bus.frame_cnt      = frame_cnt_q;
  assign bus.photon_cnt     = phot_cnt;
  assign bus.status         = pack_status(state_q == ST_ARMED, state_q == ST_CAPT,
                                          done_q, phot_sat, aborted_q);
endmodule

// File: tb/tb_wvl_capture_ctrl.sv
// Drives a 32-bit and an 8-bit sequencer from the same stimulus and checks
// both against a run-level reference model every cycle plus directed scenarios.
module tb_wvl_capture_ctrl;
  logic        clk = 1'b0;
  logic        srst;
  logic [31:0] cfg_ctrl;
  logic [31:0] cfg_num;
  logic        frame_sync;
  logic        photon_valid;
  int          n_vec = 0;
  int          n_err = 0;
  int          win_hi = 0;

  always #5 clk = ~clk;

  wvl_capture_ctrl_if #(.CNT_W(32)) bus_w ();
  wvl_capture_ctrl_if #(.CNT_W(8))  bus_n ();

  assign bus_w.cfg_ctrl       = cfg_ctrl;
  assign bus_w.cfg_num_frames = cfg_num;
  assign bus_w.frame_sync     = frame_sync;
  assign bus_w.photon_valid   = photon_valid;
  assign bus_n.cfg_ctrl       = cfg_ctrl;
  assign bus_n.cfg_num_frames = cfg_num[7:0];
  assign bus_n.frame_sync     = frame_sync;
  assign bus_n.photon_valid   = photon_valid;

  wvl_capture_ctrl #(.CNT_W(32)) dut_w (.user_clk(clk), .user_rst(srst), .bus(bus_w));
  wvl_capture_ctrl #(.CNT_W(8))  dut_n (.user_clk(clk), .user_rst(srst), .bus(bus_n));

  // Reference model, one slot per DUT width: 0 = 32-bit, 1 = 8-bit
  logic [31:0] m_fc[2], m_ph[2], m_num[2];
  bit          m_wait[2], m_run[2], m_done[2], m_abt[2], m_sat[2], m_cal[2];
  bit          m_arm_h[2], m_abt_h[2];

  function automatic logic [31:0] mask(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] m_status(input int i);
    return {27'b0, m_abt[i], m_sat[i], m_done[i], m_run[i], m_wait[i]};
  endfunction

  task automatic model_step(input int i);
    bit arm_p, abort_p;
    if (srst) begin
      m_fc[i] = 0; m_ph[i] = 0; m_num[i] = 0;
      m_wait[i] = 0; m_run[i] = 0; m_done[i] = 0; m_abt[i] = 0; m_sat[i] = 0;
      m_cal[i] = 0; m_arm_h[i] = 0; m_abt_h[i] = 0;
      return;
    end
    arm_p      = cfg_ctrl[0] && !m_arm_h[i];
    abort_p    = cfg_ctrl[2] && !m_abt_h[i];
    m_arm_h[i] = cfg_ctrl[0];
    m_abt_h[i] = cfg_ctrl[2];
    if (frame_sync) m_cal[i] = cfg_ctrl[1];
    if (m_run[i] && photon_valid) begin
      if (m_ph[i] != mask(i)) m_ph[i] = m_ph[i] + 1;
      if (m_ph[i] == mask(i)) m_sat[i] = 1;
    end
    if (m_run[i]) begin
      if (abort_p) begin
        m_run[i] = 0; m_abt[i] = 1;
      end else if (frame_sync) begin
        if (m_num[i] != 0 && m_fc[i] == m_num[i]) begin
          m_run[i] = 0; m_done[i] = 1;
        end else begin
          m_fc[i] = (m_fc[i] + 1) & mask(i);
        end
      end
    end else if (m_wait[i]) begin
      if (abort_p) begin
        m_wait[i] = 0; m_abt[i] = 1;
      end else if (frame_sync) begin
        m_wait[i] = 0; m_run[i] = 1; m_fc[i] = 1;
      end
    end else if (arm_p) begin
      m_wait[i] = 1; m_fc[i] = 0; m_ph[i] = 0;
      m_done[i] = 0; m_abt[i] = 0; m_sat[i] = 0;
      m_num[i] = cfg_num & mask(i);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("w.cap",    32'(bus_w.cap_window),     32'(m_run[0]));
    check("w.cal",    32'(bus_w.use_energy_cal), 32'(m_cal[0]));
    check("w.fcnt",   bus_w.frame_cnt,           m_fc[0]);
    check("w.pcnt",   bus_w.photon_cnt,          m_ph[0]);
    check("w.status", bus_w.status,              m_status(0));
    check("n.cap",    32'(bus_n.cap_window),     32'(m_run[1]));
    check("n.cal",    32'(bus_n.use_energy_cal), 32'(m_cal[1]));
    check("n.fcnt",   32'(bus_n.frame_cnt),      m_fc[1]);
    check("n.pcnt",   32'(bus_n.photon_cnt),     m_ph[1]);
    check("n.status", bus_n.status,              m_status(1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (bus_w.cap_window) win_hi++;
    compare_all();
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic arm_edge();
    cfg_ctrl[0] = 1'b1;
    tick();
    cfg_ctrl[0] = 1'b0;
  endtask

  task automatic abort_edge();
    cfg_ctrl[2] = 1'b1;
    tick();
    cfg_ctrl[2] = 1'b0;
    tick();
  endtask

  initial begin
    srst = 1'b1; cfg_ctrl = '0; cfg_num = '0; frame_sync = 1'b0; photon_valid = 1'b0;
    cycles(2);
    check("rst.status", bus_w.status, 32'h0);
    check("rst.cap",    32'(bus_w.cap_window), 32'h0);
    srst = 1'b0;
    tick();

    // reset during capture at frame 3 of 10
    cfg_num = 10;
    arm_edge();
    for (int k = 0; k < 3; k++) begin
      cycles(5);
      pulse_sync();
    end
    photon_valid = 1'b1;
    cycles(5);
    check("s1.fcnt_pre", bus_w.frame_cnt, 32'd3);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    photon_valid = 1'b0;
    check("s1.cap",    32'(bus_w.cap_window), 32'h0);
    check("s1.status", bus_w.status, 32'h0);
    check("s1.fcnt",   bus_w.frame_cnt, 32'h0);
    check("s1.pcnt",   bus_w.photon_cnt, 32'h0);
    $display("scenario reset-mid-capture done");

    // four counted frames from six syncs, arm level held high throughout
    cfg_num = 4;
    photon_valid = 1'b1;
    cfg_ctrl[0] = 1'b1;
    tick();
    win_hi = 0;
    for (int k = 0; k < 6; k++) begin
      pulse_sync();
      cycles(99);
    end
    check("s2.window_cycles", win_hi, 32'd400);
    check("s2.fcnt",     bus_w.frame_cnt, 32'd4);
    check("s2.status",   bus_w.status, 32'h4);
    check("s2.pcnt",     bus_w.photon_cnt, 32'd400);
    check("s2.n_pcnt",   32'(bus_n.photon_cnt), 32'd255);
    check("s2.n_status", bus_n.status, 32'hC);
    photon_valid = 1'b0;
    cfg_ctrl[0] = 1'b0;
    tick();
    cfg_ctrl[0] = 1'b1;
    tick();
    check("s2.rearm_status", bus_w.status, 32'h1);
    check("s2.rearm_fcnt",   bus_w.frame_cnt, 32'h0);
    check("s2.rearm_pcnt",   bus_w.photon_cnt, 32'h0);
    cfg_ctrl[0] = 1'b0;
    abort_edge();
    $display("scenario counted-frames and re-arm done");

    // calibration select moves only at frame starts
    cfg_num = 0;
    arm_edge();
    pulse_sync();
    cycles(10);
    cfg_ctrl[1] = 1'b1;
    cycles(20);
    check("s3.cal_mid_hold", 32'(bus_w.use_energy_cal), 32'h0);
    pulse_sync();
    check("s3.cal_after_sync", 32'(bus_w.use_energy_cal), 32'h1);
    cfg_ctrl[1] = 1'b0;
    cycles(15);
    check("s3.cal_mid_hold2", 32'(bus_w.use_energy_cal), 32'h1);
    pulse_sync();
    check("s3.cal_after_sync2", 32'(bus_w.use_energy_cal), 32'h0);
    abort_edge();
    $display("scenario energy-cal alignment done");

    // abort coincident with frame sync at frame 2
    cfg_num = 10;
    arm_edge();
    cycles(3);
    pulse_sync();
    cycles(5);
    pulse_sync();
    cycles(5);
    cfg_ctrl[2] = 1'b1;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    cfg_ctrl[2] = 1'b0;
    check("s4.cap",    32'(bus_w.cap_window), 32'h0);
    check("s4.fcnt",   bus_w.frame_cnt, 32'd2);
    check("s4.status", bus_w.status, 32'h10);
    tick();
    $display("scenario abort-with-sync done");

    // continuous mode saturation on the 8-bit build
    cfg_num = 0;
    arm_edge();
    pulse_sync();
    photon_valid = 1'b1;
    cycles(300);
    photon_valid = 1'b0;
    check("s5.n_pcnt",   32'(bus_n.photon_cnt), 32'd255);
    check("s5.n_status", bus_n.status, 32'hA);
    check("s5.pcnt",     bus_w.photon_cnt, 32'd300);
    abort_edge();
    $display("scenario photon saturation done");

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      frame_sync   = ($urandom_range(0, 19) == 0);
      photon_valid = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 29) == 0) cfg_ctrl[0] = ~cfg_ctrl[0];
      if ($urandom_range(0, 14) == 0) cfg_ctrl[1] = ~cfg_ctrl[1];
      if ($urandom_range(0, 79) == 0) cfg_ctrl[2] = ~cfg_ctrl[2];
      if ($urandom_range(0, 99) == 0) cfg_ctrl[31:3] = 29'($urandom);
      if ($urandom_range(0, 39) == 0) cfg_num = $urandom_range(0, 5);
      srst = ($urandom_range(0, 499) == 0);
      tick();
    end
    srst = 1'b0; frame_sync = 1'b0; photon_valid = 1'b0;
    tick();
    $display("scenario random traffic done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
